// File: rtl/data_ram_resp_if.sv
// data_ram_resp_if: core load/store port bundle between the MEM stage and the data RAM responder
interface data_ram_resp_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    modport master (output ce, we, addr, sel, data_i, input data_o);
    modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/data_ram_resp.sv
// data_ram_resp: big-endian word RAM with byte-lane writes, combinational reads and a status window
module data_ram_resp #(
    parameter int       ADDR_W   = 10,
    parameter bit [3:0] MMIO_TAG = 4'hF
) (
    input logic           clk,
    input logic           rst,
    data_ram_resp_if.slave bus
);
    logic [31:0] mem [0:2**ADDR_W-1];
    logic [31:0] cycle_cnt, rdcnt, wrcnt, scratch, mmio_val;
    logic [ADDR_W-1:0] idx;
    logic [1:0] off;
    logic mmio, rd_en, wr_en;
    logic unused_addr_bits;
    assign mmio = bus.addr[31:28] == MMIO_TAG;
    assign idx = bus.addr[ADDR_W+1:2];
    assign off = bus.addr[3:2];
    assign rd_en = rst & bus.ce & ~bus.we;
    assign wr_en = rst & bus.ce & bus.we;
    assign unused_addr_bits = &{1'b0, bus.addr[27:ADDR_W+2], bus.addr[1:0]};
    // Status window read mux and the same-cycle load data returned to the core
    always_comb begin
        mmio_val = off == 2'd0 ? cycle_cnt :
                   off == 2'd1 ? rdcnt :
                   off == 2'd2 ? wrcnt : scratch;
        bus.data_o = !rd_en ? 32'h0 : mmio ? mmio_val : mem[idx];
    end
    // Byte-lane RAM store; the array is deliberately left out of reset so contents survive it
    always_ff @(posedge clk) begin
        if (wr_en && !mmio)
            for (int i = 0; i < 4; i++)
                if (bus.sel[i]) mem[idx][8*i +: 8] <= bus.data_i[8*i +: 8];
    end
    // Free-running cycle counter, access counters and byte-writable scratch register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt <= '0;
            rdcnt     <= '0;
            wrcnt     <= '0;
            scratch   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (rd_en) rdcnt <= rdcnt + 32'd1;
            if (wr_en) wrcnt <= wrcnt + 32'd1;
            if (wr_en && mmio && off == 2'd3)
                for (int i = 0; i < 4; i++)
                    if (bus.sel[i]) scratch[8*i +: 8] <= bus.data_i[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: table-driven scoreboard bench for the data RAM responder
module tb_data_ram_resp;
    typedef struct {
        logic        rst_n;
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    logic [31:0] sb[$];

    data_ram_resp_if bus();
    data_ram_resp dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic c, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.rst_n = r; v.ce = c; v.we = w; v.addr = a; v.sel = s; v.d = d; v.exp = e;
        tbl.push_back(v);
    endtask

    // one access per cycle: drive after the edge, push expectation, compare on the falling edge
    task automatic step(input vec_t v, input int n);
        logic [31:0] e;
        @(posedge clk);
        #2;
        rst = v.rst_n; bus.ce = v.ce; bus.we = v.we; bus.addr = v.addr; bus.sel = v.sel; bus.data_i = v.d;
        sb.push_back(v.exp);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (bus.data_o !== e) begin
            errors++;
            $display("FAIL step%0d addr=%h: data_o=%h expected=%h", n, v.addr, bus.data_o, e);
        end
    endtask

    initial begin
        vec_t v;
        bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.sel = '0; bus.data_i = '0;
        // rows: rst_n ce we addr sel data expected_data_o
        add(1,1,0,32'hF0000004,4'h0,32'h0,32'h0);        // RDCNT after reset
        add(1,1,0,32'hF0000008,4'h0,32'h0,32'h0);        // WRCNT after reset
        add(1,1,1,32'h00000010,4'hF,32'hAABBCCDD,32'h0);
        add(1,1,1,32'h00000010,4'h4,32'h11223344,32'h0);
        add(1,1,0,32'h00000010,4'h0,32'h0,32'hAA22CCDD);
        add(1,1,1,32'h00000020,4'hF,32'h00000000,32'h0);
        add(1,1,1,32'h00000020,4'h1,32'h000000EE,32'h0);
        add(1,1,1,32'h00000020,4'h8,32'hFF000000,32'h0);
        add(1,1,0,32'h00000020,4'h0,32'h0,32'hFF0000EE);
        add(1,0,0,32'h00000020,4'hF,32'h0,32'h0);        // ce=0 gives zero
        add(1,1,1,32'h00001004,4'hF,32'h12345678,32'h0);
        add(1,1,0,32'h00000004,4'h0,32'h0,32'h12345678); // alias of 0x1004
        add(1,1,0,32'hF0000004,4'h0,32'h0,32'd5);        // MMIO, not RAM: RDCNT=5
        add(1,1,1,32'h00000004,4'h0,32'hFFFFFFFF,32'h0); // sel=0 write
        add(1,1,0,32'h00000004,4'h0,32'h0,32'h12345678);
        add(1,1,0,32'hF0000008,4'h0,32'h0,32'd7);        // WRCNT incl. sel=0
        add(1,1,0,32'hF0000000,4'h0,32'h0,32'd16);       // CYCLE
        add(1,1,1,32'hF000000C,4'h3,32'hDEADBEEF,32'h0);
        add(1,1,0,32'hF000000C,4'h0,32'h0,32'h0000BEEF);
        add(1,1,1,32'h00000000,4'hF,32'h00000000,32'h0);
        add(1,1,1,32'hF0000000,4'hF,32'h55555555,32'h0); // RO write
        add(1,1,0,32'hF0000000,4'h0,32'h0,32'd21);       // CYCLE unaffected
        add(1,1,0,32'h00000000,4'h0,32'h0,32'h0);        // RAM word 0 unaffected
        add(1,1,0,32'hF0000008,4'h0,32'h0,32'd10);
        add(1,1,0,32'hF0000004,4'h0,32'h0,32'd13);
        add(1,1,1,32'h00000030,4'hF,32'h01020304,32'h0);
        add(0,1,1,32'h00000030,4'hF,32'hDDDDDDDD,32'h0); // reset lands on a write
        add(1,1,0,32'hF000000C,4'h0,32'h0,32'h0);
        add(1,1,0,32'hF0000008,4'h0,32'h0,32'h0);
        add(1,1,0,32'h00000010,4'h0,32'h0,32'hAA22CCDD); // RAM survives reset
        add(1,1,0,32'h00000030,4'h0,32'h0,32'h01020304); // suppressed write
        add(1,1,0,32'hF0000000,4'h0,32'h0,32'd4);
        add(1,1,0,32'hF0000004,4'h0,32'h0,32'd5);
        add(1,0,0,32'h00000000,4'h0,32'h0,32'h0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
        // RDCNT wrap: preset the counter between edges, then read it twice
        @(negedge clk);
        force dut.rdcnt = 32'hFFFFFFFF;
        release dut.rdcnt;
        v = '{1'b1, 1'b1, 1'b0, 32'hF0000004, 4'h0, 32'h0, 32'hFFFFFFFF};
        step(v, 100);
        v.exp = 32'h0;
        step(v, 101);
        v = '{1'b1, 1'b1, 1'b1, 32'h00000010, 4'hF, 32'h0, 32'h0};
        step(v, 102);                                    // write gates data_o
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Data-memory responder for the CPU core's load/store port. It is the slave end of the core's ram_addr/ram_data/ram_we/ram_sel/ram_ce interface.
- Provides a word-organised big-endian RAM with byte-lane writes and a same-cycle (combinational) read, matching a MEM stage that samples read data in the cycle it issues the address.
- Also exposes a small memory-mapped status window holding a cycle counter, access counters and a scratch register, used by test programs.

Parameters:
- ADDR_W, 10, word-index width; RAM holds 2^ADDR_W 32-bit words (default 4 KB).
- MMIO_TAG, 4'hF, value of addr[31:28] that selects the status window instead of RAM.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- ce  input  1  access enable from the core.
- we  input  1  1 = write, 0 = read; qualified by ce.
- addr  input  32  byte address.
- sel  input  4  byte-lane select; sel[3] = data[31:24] = byte offset 0 (big-endian), sel[0] = data[7:0] = offset 3.
- data_i  input  32  store data from the core.
- data_o  output  32  load data to the core.

Behaviour:
- Decode:
  - mmio = (addr[31:28] == MMIO_TAG).
  - RAM word index = addr[ADDR_W+1:2]. Upper non-tag bits and addr[1:0] are ignored, so RAM aliases.
  - MMIO offset = addr[3:2]; addr[27:4] are ignored.
- Read path (combinational):
  - data_o = 0 when ce=0 or we=1 or rst=0.
  - Otherwise data_o is the full 32-bit word; sel does not mask reads, and the core extracts bytes itself.
  - RAM read returns the array content before the current edge. A write and read to the same word cannot coexist in one cycle.
- Write path: on posedge, if rst=1 & ce=1 & we=1, each lane with sel[i]=1 is updated from the matching data_i lane. Other lanes are unchanged.
- MMIO map (offset : register):
  - 0 : CYCLE, read-only, +1 every cycle while rst=1.
  - 1 : RDCNT, read-only, +1 per cycle with ce=1 & we=0 (RAM or MMIO).
  - 2 : WRCNT, read-only, +1 per cycle with ce=1 & we=1 (RAM or MMIO, any sel including 0).
  - 3 : SCRATCH, read/write, byte-lane writable like RAM.
- MMIO access rules:
  - Writes to offsets 0-2 are ignored, but still count in WRCNT.
  - MMIO writes never touch RAM.
- MMIO read values: reads return the register value before the edge. For example, a read of RDCNT returns the count excluding the current access.
- Counters: 32-bit and wrap 0xFFFFFFFF -> 0 with no flag.
- Reset (rst=0 at posedge):
  - CYCLE, RDCNT, WRCNT and SCRATCH are cleared to 0. Any write in that cycle is suppressed, and that cycle does not count.
  - The RAM array is not reset; it keeps its contents across reset, including when reset lands mid-program.
  - Simulation preload of the array is permitted by the bench; the RTL carries no initial contents.
- sel=0 with we=1: no data change, counted as a write.
- ce=0: no state change other than CYCLE; we, sel and addr are don't-care.
- Latency:
  - Read: 0 cycles, combinational from addr/ce/we.
  - Write: visible to a read in the cycle after the edge.
- No handshake or stall output; every access completes in one cycle.

Test Plan:
- Byte-lane write: rst released, write addr 0x00000010 data 0xAABBCCDD sel 4'b1111, then write data 0x11223344 sel 4'b0100 -> read 0x10 returns 0xAA22CCDD.
- Big-endian lanes: write 0x000000EE sel 4'b0001 to 0x20 over a zeroed word, then 0xFF000000 sel 4'b1000 -> read returns 0xFF0000EE; ce=0 cycle -> data_o=0.
- Aliasing: with ADDR_W=10, write 0x12345678 to 0x00001004 -> read of 0x00000004 returns 0x12345678; read of 0xF0000004 does not.
- Counters:
  - After reset, 3 reads and 2 writes (one with sel=0) -> RDCNT read returns 3 and WRCNT read returns 2.
  - CYCLE read N cycles after reset release returns N.
- SCRATCH and RO protection:
  - Write 0xDEADBEEF sel 4'b0011 to 0xF000000C -> reads 0x0000BEEF.
  - Write to 0xF0000000 leaves CYCLE unchanged and leaves RAM word 0 unchanged.
- Mid-run reset:
  - Assert rst=0 for 1 cycle during a write to 0x30 -> write suppressed; all MMIO registers read 0 afterwards.
  - RAM word at 0x10 still holds 0xAA22CCDD.
  - Force RDCNT to 0xFFFFFFFF and read once -> RDCNT wraps to 0.
